// File: rtl/alu_pkg.sv
// Shared types for the integer ALU issue stage: ALU select codes, RV32I/Zbb
// opcode fields, the decoded-op record and the skid buffer state encoding.
package alu_pkg;

  typedef enum logic [4:0] {
    SEL_ADD  = 5'd0,
    SEL_SUB  = 5'd1,
    SEL_OR   = 5'd2,
    SEL_XOR  = 5'd3,
    SEL_AND  = 5'd4,
    SEL_SLL  = 5'd5,
    SEL_SRL  = 5'd6,
    SEL_SRA  = 5'd7,
    SEL_SLLI = 5'd8,
    SEL_SRLI = 5'd9,
    SEL_SRAI = 5'd10,
    SEL_ZERO = 5'd11,
    SEL_ONE  = 5'd12,
    SEL_PASS = 5'd13,
    SEL_CLZ  = 5'd14,
    SEL_CTZ  = 5'd15,
    SEL_CPOP = 5'd16
  } alu_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_ZBB  = 7'b0110000;

  localparam logic [4:0] ZBB_RS2_CLZ  = 5'd0;
  localparam logic [4:0] ZBB_RS2_CTZ  = 5'd1;
  localparam logic [4:0] ZBB_RS2_CPOP = 5'd2;

  typedef struct packed {
    alu_sel_e    sel;
    logic [31:0] number1;
    logic [31:0] number2;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic        we;
    logic        illegal;
  } decoded_op_t;

  // Occupancy of the main/skid register pair; main always holds the oldest op.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Sign-extended I-type immediate.
  function automatic logic [31:0] imm_i_of(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of one RV32I/Zbb integer instruction plus its register
// operands into the ALU select/operand record. Set-less-than is resolved here
// so the ALU only ever sees a ONE or ZERO select for it.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter bit ZBB_EN = 1'b1
) (
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output decoded_op_t op
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs2_field;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        legal;

  assign opcode    = instr[6:0];
  assign rd        = instr[11:7];
  assign funct3    = instr[14:12];
  assign rs2_field = instr[24:20];
  assign funct7    = instr[31:25];
  assign imm_i     = imm_i_of(instr);
  assign imm_u     = {instr[31:12], 12'b0};

  // Field decode; anything not explicitly matched stays illegal.
  always_comb begin
    op         = '0;
    legal      = 1'b0;
    op.number1 = rs1_data;
    case (opcode)
      OPC_OP: begin
        op.number2 = rs2_data;
        if (funct7 == F7_BASE) begin
          legal = 1'b1;
          case (funct3)
            F3_ADD:  op.sel = SEL_ADD;
            F3_SLL:  op.sel = SEL_SLL;
            F3_SLT:  op.sel = ($signed(rs1_data) < $signed(rs2_data)) ? SEL_ONE : SEL_ZERO;
            F3_SLTU: op.sel = (rs1_data < rs2_data) ? SEL_ONE : SEL_ZERO;
            F3_XOR:  op.sel = SEL_XOR;
            F3_SR:   op.sel = SEL_SRL;
            F3_OR:   op.sel = SEL_OR;
            F3_AND:  op.sel = SEL_AND;
            default: legal = 1'b0;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            F3_ADD: begin
              legal  = 1'b1;
              op.sel = SEL_SUB;
            end
            F3_SR: begin
              legal  = 1'b1;
              op.sel = SEL_SRA;
            end
            default: legal = 1'b0;
          endcase
        end
      end
      OPC_OP_IMM: begin
        op.number2 = imm_i;
        case (funct3)
          F3_ADD: begin
            legal  = 1'b1;
            op.sel = SEL_ADD;
          end
          F3_SLT: begin
            legal  = 1'b1;
            op.sel = ($signed(rs1_data) < $signed(imm_i)) ? SEL_ONE : SEL_ZERO;
          end
          F3_SLTU: begin
            legal  = 1'b1;
            op.sel = (rs1_data < imm_i) ? SEL_ONE : SEL_ZERO;
          end
          F3_XOR: begin
            legal  = 1'b1;
            op.sel = SEL_XOR;
          end
          F3_OR: begin
            legal  = 1'b1;
            op.sel = SEL_OR;
          end
          F3_AND: begin
            legal  = 1'b1;
            op.sel = SEL_AND;
          end
          F3_SLL: begin
            if (funct7 == F7_BASE) begin
              legal    = 1'b1;
              op.sel   = SEL_SLLI;
              op.shamt = rs2_field;
            end else if ((funct7 == F7_ZBB) && ZBB_EN) begin
              case (rs2_field)
                ZBB_RS2_CLZ: begin
                  legal  = 1'b1;
                  op.sel = SEL_CLZ;
                end
                ZBB_RS2_CTZ: begin
                  legal  = 1'b1;
                  op.sel = SEL_CTZ;
                end
                ZBB_RS2_CPOP: begin
                  legal  = 1'b1;
                  op.sel = SEL_CPOP;
                end
                default: legal = 1'b0;
              endcase
            end
          end
          F3_SR: begin
            if (funct7 == F7_BASE) begin
              legal    = 1'b1;
              op.sel   = SEL_SRLI;
              op.shamt = rs2_field;
            end else if (funct7 == F7_ALT) begin
              // Arithmetic immediate shift reuses the register SRA path with
              // the shift amount carried in number2.
              legal      = 1'b1;
              op.sel     = SEL_SRA;
              op.number2 = {27'b0, rs2_field};
              op.shamt   = rs2_field;
            end
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        legal      = 1'b1;
        op.sel     = SEL_PASS;
        op.number1 = imm_u;
        op.number2 = '0;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      op     = '0;
      op.sel = SEL_ZERO;
    end
    op.rd      = rd;
    op.illegal = ~legal;
    op.we      = legal && (rd != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes the incoming op and holds it in a main/skid register
// pair so one op per cycle flows under back-pressure.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. out_* fields are held stable while out_valid && !out_ready. in_ready is
// a function of registered state only (no combinational path from out_ready).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter bit ZBB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_sel,
  output logic [31:0] out_number1,
  output logic [31:0] out_number2,
  output logic [4:0]  out_shamt,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_illegal,
  output logic [1:0]  dbg_state
);

  decoded_op_t dec_op;
  decoded_op_t main_q;
  decoded_op_t skid_q;
  buf_state_e  state_q;
  buf_state_e  state_d;
  logic        accept;
  logic        drain;
  logic        load_main_new;
  logic        load_main_skid;
  logic        load_skid;

  alu_op_decode #(
    .ZBB_EN(ZBB_EN)
  ) u_decode (
    .instr    (in_instr),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .op       (dec_op)
  );

  assign in_ready  = (state_q != BUF_TWO);
  assign out_valid = (state_q != BUF_EMPTY);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;
  assign dbg_state = state_q;

  // Buffer occupancy transitions and register load strobes; flush overrides all.
  always_comb begin
    state_d        = state_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          state_d       = BUF_ONE;
          load_main_new = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && !drain) begin
          state_d   = BUF_TWO;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_main_new = 1'b1;
        end else if (drain) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (drain) begin
          state_d        = BUF_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (flush) begin
      state_d        = BUF_EMPTY;
      load_main_new  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Main register drives the outputs; cleared on flush so nothing stale lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
    end else if (flush) begin
      main_q <= '0;
    end else if (load_main_new) begin
      main_q <= dec_op;
    end else if (load_main_skid) begin
      main_q <= skid_q;
    end
  end

  // Skid register catches the op accepted while the main register is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '0;
    end else if (flush) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= dec_op;
    end
  end

  assign out_sel     = main_q.sel;
  assign out_number1 = main_q.number1;
  assign out_number2 = main_q.number2;
  assign out_shamt   = main_q.shamt;
  assign out_rd      = main_q.rd;
  assign out_we      = main_q.we;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vectors, back-pressure ordering,
// flush and asynchronous reset. A second instance built without Zbb checks
// that CLZ is flagged illegal there.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_sel;
  logic [31:0] out_number1;
  logic [31:0] out_number2;
  logic [4:0]  out_shamt;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;
  logic [1:0]  dbg_state;

  logic        z_in_ready;
  logic        z_out_valid;
  logic [4:0]  z_sel;
  logic [31:0] z_number1;
  logic [31:0] z_number2;
  logic [4:0]  z_shamt;
  logic [4:0]  z_rd;
  logic        z_we;
  logic        z_illegal;
  logic [1:0]  z_state;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  alu_issue_stage #(.ZBB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sel(out_sel), .out_number1(out_number1), .out_number2(out_number2),
    .out_shamt(out_shamt), .out_rd(out_rd), .out_we(out_we),
    .out_illegal(out_illegal), .dbg_state(dbg_state)
  );

  alu_issue_stage #(.ZBB_EN(1'b0)) dut_nozbb (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(z_out_valid), .out_ready(1'b1),
    .out_sel(z_sel), .out_number1(z_number1), .out_number2(z_number2),
    .out_shamt(z_shamt), .out_rd(z_rd), .out_we(z_we),
    .out_illegal(z_illegal), .dbg_state(z_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
    in_valid    = 1'b1;
    in_instr    = instr;
    in_rs1_data = r1;
    in_rs2_data = r2;
    step();
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LUI = 7'b0110111;

  initial begin
    bit c_pending;
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    out_ready   = 1'b1;
    step();
    step();

    // reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_sel", 32'(out_sel), 32'd0);
    check("rst_number1", out_number1, 32'd0);
    check("rst_number2", out_number2, 32'd0);
    check("rst_rd_we", {out_rd, out_we, out_illegal}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // ADDI x1, x2, -5 with rs1=10
    send(32'hFFB10093, 32'd10, 32'd0);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_sel", 32'(out_sel), 32'd0);
    check("addi_n1", out_number1, 32'd10);
    check("addi_n2", out_number2, 32'hFFFFFFFB);
    check("addi_rd", 32'(out_rd), 32'd1);
    check("addi_we", 32'(out_we), 32'd1);

    // SLT: -1 < 1 signed -> ONE
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b010, 5'd5, OP), 32'hFFFFFFFF, 32'd1);
    check("slt_sel", 32'(out_sel), 32'd12);
    check("slt_we", 32'(out_we), 32'd1);
    // SLTU: 0xFFFFFFFF < 1 unsigned is false -> ZERO, still legal
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd5, OP), 32'hFFFFFFFF, 32'd1);
    check("sltu_sel", 32'(out_sel), 32'd11);
    check("sltu_illegal", 32'(out_illegal), 32'd0);

    // CLZ x3 on both builds
    send(32'h60021193, 32'h80, 32'd0);
    check("clz_sel", 32'(out_sel), 32'd14);
    check("clz_rd", 32'(out_rd), 32'd3);
    check("clz_we", 32'(out_we), 32'd1);
    check("nozbb_sel", 32'(z_sel), 32'd11);
    check("nozbb_illegal", 32'(z_illegal), 32'd1);
    check("nozbb_we", 32'(z_we), 32'd0);

    // SRAI x6, x4, 7
    send(enc_i(12'h407, 5'd4, 3'b101, 5'd6, OPI), 32'h80000000, 32'd0);
    check("srai_sel", 32'(out_sel), 32'd7);
    check("srai_n1", out_number1, 32'h80000000);
    check("srai_n2", out_number2, 32'd7);
    check("srai_shamt", 32'(out_shamt), 32'd7);

    // SUB
    send(enc_r(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7, OP), 32'd9, 32'd4);
    check("sub_sel", 32'(out_sel), 32'd1);
    check("sub_n2", out_number2, 32'd4);

    // LUI x2, 0x12345
    send({20'h12345, 5'd2, LUI}, 32'hDEADBEEF, 32'd0);
    check("lui_sel", 32'(out_sel), 32'd13);
    check("lui_n1", out_number1, 32'h12345000);
    check("lui_rd", 32'(out_rd), 32'd2);

    // MUL (reserved funct7 for this stage) -> illegal
    send(enc_r(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd8, OP), 32'd3, 32'd5);
    check("mul_sel", 32'(out_sel), 32'd11);
    check("mul_illegal", 32'(out_illegal), 32'd1);
    check("mul_we", 32'(out_we), 32'd0);

    // ADD to x0 -> no write
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd0, OP), 32'd1, 32'd2);
    check("x0_sel", 32'(out_sel), 32'd0);
    check("x0_we", 32'(out_we), 32'd0);

    // CPOP
    send(enc_i({7'b0110000, 5'd2}, 5'd1, 3'b001, 5'd9, OPI), 32'hF0F0, 32'd0);
    check("cpop_sel", 32'(out_sel), 32'd16);

    // SLLI shamt 3
    send(enc_i({7'b0, 5'd3}, 5'd1, 3'b001, 5'd10, OPI), 32'd1, 32'd0);
    check("slli_sel", 32'(out_sel), 32'd8);
    check("slli_shamt", 32'(out_shamt), 32'd3);

    // SLTIU against -1: every value except 0xFFFFFFFF is below it
    send(enc_i(12'hFFF, 5'd1, 3'b011, 5'd11, OPI), 32'd5, 32'd0);
    check("sltiu_sel", 32'(out_sel), 32'd12);

    in_valid = 1'b0;
    step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_state", 32'(dbg_state), 32'd0);

    // Back-pressure: A, B fill the buffer, C is held off
    out_ready = 1'b0;
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hB);
    exp_q.push_back(32'hC);
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'hA, 32'd0);
    check("bp_one_ready", 32'(in_ready), 32'd1);
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'hB, 32'd0);
    check("bp_two_ready", 32'(in_ready), 32'd0);
    check("bp_two_state", 32'(dbg_state), 32'd2);
    check("bp_two_head", out_number1, 32'hA);
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'hC, 32'd0);
    check("bp_hold_ready", 32'(in_ready), 32'd0);
    check("bp_hold_head", out_number1, 32'hA);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      c_pending = in_valid && in_ready;
      if (out_valid) check("bp_order", out_number1, exp_q.pop_front());
      step();
      if (c_pending) in_valid = 1'b0;
    end
    check("bp_drain_left", exp_q.size(), 32'd0);
    check("bp_drain_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;

    // Flush in TWO with a new op offered
    out_ready = 1'b0;
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'h11, 32'd0);
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'h22, 32'd0);
    check("fl_two_state", 32'(dbg_state), 32'd2);
    flush       = 1'b1;
    in_rs1_data = 32'hDD;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_two_valid", 32'(out_valid), 32'd0);
    check("fl_two_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step();
    check("fl_two_no_new", 32'(out_valid), 32'd0);

    // Flush in ONE wins over a same-cycle accept
    out_ready = 1'b0;
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'h33, 32'd0);
    check("fl_one_state", 32'(dbg_state), 32'd1);
    flush       = 1'b1;
    in_rs1_data = 32'hEE;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_one_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    step();
    check("fl_one_no_new", 32'(out_valid), 32'd0);

    // Asynchronous reset while holding two ops
    out_ready = 1'b0;
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'h44, 32'd0);
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'h55, 32'd0);
    in_valid = 1'b0;
    check("ar_two_state", 32'(dbg_state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("ar_async_valid", 32'(out_valid), 32'd0);
    check("ar_async_n1", out_number1, 32'd0);
    check("ar_async_ready", 32'(in_ready), 32'd1);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    check("ar_after1_valid", 32'(out_valid), 32'd0);
    step();
    check("ar_after2_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
